// File: rtl/bin_to_sseg_display_pkg.sv
// Shared segment patterns, FSM state type and leading-zero mask for the result display.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bin_to_sseg_display_pkg;

   localparam int BCD_DIGITS   = 7;
   localparam int NUM_DISPLAYS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Bit i set when digit i sits above the most significant nonzero digit; digit 0 always shown.
   function automatic logic [BCD_DIGITS-1:0] lzb_mask(input logic [4*BCD_DIGITS-1:0] bcd);
      logic seen;
      lzb_mask = '0;
      seen     = 1'b0;
      for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
         seen        = seen | (bcd[4*i +: 4] != 4'd0);
         lzb_mask[i] = ~seen;
      end
   endfunction

endpackage

// File: rtl/bin_to_sseg_display_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment pattern; zero latency, no flow control.
// Blank flag or a non-decimal code (10..15) yields an all-off pattern.
module bcd_to_sseg
   import bin_to_sseg_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bin_to_sseg_display.sv
// Signed-magnitude to BCD (double dabble, one bit/clk, done at WIDTH+1) plus 8-digit scan; starts while busy are dropped.
// Optional leading-zero blanking under SSEG_LZB_EN.
module bin_to_sseg_display
   import bin_to_sseg_display_pkg::*;
#(
   parameter int WIDTH    = 20,
   parameter int SCAN_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH-1:0]        num,
   input  logic                    neg,
   output logic                    busy,
   output logic                    done,
   output logic [6:0]              Sseg,
   output logic [NUM_DISPLAYS-1:0] anodos
);

   localparam int BCD_W  = 4 * BCD_DIGITS;
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = $clog2(NUM_DISPLAYS);

`ifdef SSEG_LZB_EN
   localparam logic [BCD_DIGITS-1:0] BLANK_RST = {{(BCD_DIGITS-1){1'b1}}, 1'b0};
`else
   localparam logic [BCD_DIGITS-1:0] BLANK_RST = '0;
`endif

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        bin_q, bin_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [BCD_W-1:0]        bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    neg_q, neg_d;
   logic [BCD_W-1:0]        disp_bcd_q, disp_bcd_d;
   logic                    disp_neg_q, disp_neg_d;
   logic [BCD_DIGITS-1:0]   disp_blank_q, disp_blank_d;
   logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
   logic [NUM_DISPLAYS-1:0] anodos_q, anodos_d;
   logic                    scan_tc;
   logic [3:0]              dig_bcd;
   logic                    dig_blank;
   logic [6:0]              dig_seg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         neg_q        <= 1'b0;
         disp_bcd_q   <= '0;
         disp_neg_q   <= 1'b0;
         disp_blank_q <= BLANK_RST;
         scan_cnt_q   <= '0;
         digit_idx_q  <= '0;
         anodos_q     <= {{(NUM_DISPLAYS-1){1'b1}}, 1'b0};
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         neg_q        <= neg_d;
         disp_bcd_q   <= disp_bcd_d;
         disp_neg_q   <= disp_neg_d;
         disp_blank_q <= disp_blank_d;
         scan_cnt_q   <= scan_cnt_d;
         digit_idx_q  <= digit_idx_d;
         anodos_q     <= anodos_d;
      end
   end

   always_comb begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      neg_d        = neg_q;
      disp_bcd_d   = disp_bcd_q;
      disp_neg_d   = disp_neg_q;
      disp_blank_d = disp_blank_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = num;
               neg_d   = neg;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // The latch is only written here, so the display never shows partial results.
            disp_bcd_d = bcd_q;
            disp_neg_d = neg_q;
`ifdef SSEG_LZB_EN
            disp_blank_d = lzb_mask(bcd_q);
`else
            disp_blank_d = '0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

   always_comb begin
      scan_tc     = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
      scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
      digit_idx_d = scan_tc ? digit_idx_q + 1'b1 : digit_idx_q;
      anodos_d    = scan_tc ? {anodos_q[NUM_DISPLAYS-2:0], anodos_q[NUM_DISPLAYS-1]} : anodos_q;
   end

   always_comb begin
      dig_bcd   = 4'd0;
      dig_blank = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (digit_idx_q == IDX_W'(i)) begin
            dig_bcd   = disp_bcd_q[4*i +: 4];
            dig_blank = disp_blank_q[i];
         end
      end
   end

   bcd_to_sseg u_bcd_to_sseg (
      .bcd   (dig_bcd),
      .blank (dig_blank),
      .seg   (dig_seg)
   );

   // The top slot carries the sign instead of a BCD digit.
   assign Sseg   = (digit_idx_q == IDX_W'(NUM_DISPLAYS - 1)) ?
                   (disp_neg_q ? SEG_MINUS : SEG_BLANK) : dig_seg;
   assign anodos = anodos_q;

endmodule

// File: tb/tb_bin_to_sseg_display.sv
// Directed self-checking bench for bin_to_sseg_display with a fast scan (SCAN_DIV=4).
module tb_bin_to_sseg_display;

   logic        clk;
   logic        rst;
   logic        start;
   logic [19:0] num;
   logic        neg;
   logic        busy;
   logic        done;
   logic [6:0]  Sseg;
   logic [7:0]  anodos;

   int checks = 0;
   int errors = 0;

   bin_to_sseg_display #(.WIDTH(20), .SCAN_DIV(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .num    (num),
      .neg    (neg),
      .busy   (busy),
      .done   (done),
      .Sseg   (Sseg),
      .anodos (anodos)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: seg_of = 7'b1000000;
         1: seg_of = 7'b1111001;
         2: seg_of = 7'b0100100;
         3: seg_of = 7'b0110000;
         4: seg_of = 7'b0011001;
         5: seg_of = 7'b0010010;
         6: seg_of = 7'b0000010;
         7: seg_of = 7'b1111000;
         8: seg_of = 7'b0000000;
         9: seg_of = 7'b0010000;
         default: seg_of = 7'h7F;
      endcase
   endfunction

   // Expected pattern in display slot idx for a latched value/sign.
   function automatic logic [6:0] exp_slot(input int v, input bit s, input int idx);
      int p;
      p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (idx == 7) return s ? 7'b0111111 : 7'h7F;
`ifdef SSEG_LZB_EN
      if (idx > 0 && v < p) return 7'h7F;
`endif
      return seg_of((v / p) % 10);
   endfunction

   task automatic wait_slot(input int idx, output bit ok);
      logic [7:0] m;
      m  = 8'h01 << idx;
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         if (anodos === ~m) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_start(input int v, input bit s);
      @(negedge clk);
      num   = 20'(v);
      neg   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; num = '0; neg = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (anodos !== 8'hFE || Sseg !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_display anodos=%h sseg=%b expected FE/1000000", anodos, Sseg);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_status busy=%b done=%b expected 0/0", busy, done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (anodos !== 8'hFE) begin
         errors++;
         $display("FAIL reset_scan_hold anodos=%h expected FE", anodos);
      end
      @(negedge clk);
      checks++;
      if (anodos !== 8'hFD) begin
         errors++;
         $display("FAIL reset_scan_step anodos=%h expected FD", anodos);
      end
      checks++;
`ifdef SSEG_LZB_EN
      if (Sseg !== 7'h7F) begin
         errors++;
         $display("FAIL reset_slot1 sseg=%b expected 1111111", Sseg);
      end
`else
      if (Sseg !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_slot1 sseg=%b expected 1000000", Sseg);
      end
`endif
   endtask

   task automatic test_convert_12345;
      bit ok;
      do_start(12345, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycle%0d busy=%b done=%b expected 1/0", k, busy, done);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle21 done=%b busy=%b expected 1/0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width done=%b expected 0", done);
      end
      for (int i = 0; i < 8; i++) begin
         wait_slot(i, ok);
         checks++;
         if (!ok || Sseg !== exp_slot(12345, 1'b0, i)) begin
            errors++;
            $display("FAIL disp_12345 idx%0d slot_found=%0d sseg=%b expected %b", i, ok, Sseg, exp_slot(12345, 1'b0, i));
         end
      end
   endtask

   task automatic test_max_negative;
      bit ok;
      do_start(1048575, 1'b1);
      repeat (20) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL max_done done=%b expected 1", done);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         wait_slot(i, ok);
         checks++;
         if (!ok || Sseg !== exp_slot(1048575, 1'b1, i)) begin
            errors++;
            $display("FAIL disp_max idx%0d slot_found=%0d sseg=%b expected %b", i, ok, Sseg, exp_slot(1048575, 1'b1, i));
         end
      end
   endtask

   task automatic test_start_while_busy;
      bit ok;
      int cyc, pulses, done_cyc;
      do_start(999, 1'b0);
      repeat (4) @(negedge clk);
      num = 20'd123; neg = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 6; pulses = 0; done_cyc = -1;
      while (cyc <= 30) begin
         if (done === 1'b1) begin
            pulses++;
            done_cyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (pulses != 1 || done_cyc != 21) begin
         errors++;
         $display("FAIL busy_start_done pulses=%0d at_cycle=%0d expected 1 at 21", pulses, done_cyc);
      end
      for (int i = 0; i < 8; i++) begin
         wait_slot(i, ok);
         checks++;
         if (!ok || Sseg !== exp_slot(999, 1'b0, i)) begin
            errors++;
            $display("FAIL disp_999 idx%0d slot_found=%0d sseg=%b expected %b", i, ok, Sseg, exp_slot(999, 1'b0, i));
         end
      end
   endtask

   task automatic test_reset_mid_conversion;
      bit ok;
      int pulses;
      do_start(555, 1'b1);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || anodos !== 8'hFE || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async busy=%b anodos=%h done=%b expected 0/FE/0", busy, anodos, done);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         if (done === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midreset_done pulses=%0d expected 0", pulses);
      end
      for (int i = 0; i < 8; i++) begin
         wait_slot(i, ok);
         checks++;
         if (!ok || Sseg !== exp_slot(0, 1'b0, i)) begin
            errors++;
            $display("FAIL disp_midreset idx%0d slot_found=%0d sseg=%b expected %b", i, ok, Sseg, exp_slot(0, 1'b0, i));
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int idx;
      do_start(42, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_done done=%b expected 1", done);
      end
      @(negedge clk);
      num = 20'd7; neg = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         idx = -1;
         for (int j = 0; j < 8; j++) if (anodos[j] === 1'b0) idx = j;
         checks++;
         if (idx < 0 || Sseg !== exp_slot(42, 1'b0, idx) || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold cycle%0d idx%0d sseg=%b done=%b expected %b/0", k, idx, Sseg, done,
                     (idx < 0) ? 7'h7F : exp_slot(42, 1'b0, idx));
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_done done=%b expected 1", done);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         wait_slot(i, ok);
         checks++;
         if (!ok || Sseg !== exp_slot(7, 1'b0, i)) begin
            errors++;
            $display("FAIL disp_7 idx%0d slot_found=%0d sseg=%b expected %b", i, ok, Sseg, exp_slot(7, 1'b0, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert_12345();
      test_max_negative();
      test_start_while_busy();
      test_reset_mid_conversion();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin_to_sseg_display.md
Name: bin_to_sseg_display

Overview:
- Result-display end of the calculator datapath; the reverse of the keypad/seven-segment-to-binary path.
- Takes a signed-magnitude binary result and converts it to BCD with a sequential double-dabble engine (one bit per clock).
- Latches the converted digits and time-multiplexes them onto the 8-digit common-anode display.
- Drives the same Sseg/anodos pins that the keypad echo path uses; a top-level mux selects between the two.

Parameters:
- WIDTH, 20, magnitude width in bits; 2^20-1 = 1048575 fits in 7 BCD digits.
- SCAN_DIV, 50000, clk cycles per display digit slot (50 MHz / 50000 = 1 kHz scan).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to convert num/neg.
- num  input  WIDTH  magnitude of the result.
- neg  input  1  sign; 1 = negative.
- busy  output  1  high while conversion is in progress.
- done  output  1  one-cycle pulse when new digits are latched.
- Sseg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- anodos  output  8  digit enables, active-low, one-hot; bit 0 = rightmost digit.

Behaviour:
- Reset, effective immediately and asynchronously:
  - busy=0, done=0, FSM=IDLE.
  - Display latch = 0 and positive.
  - Scan counter = 0, digit index = 0, anodos=8'hFE.
  - Sseg=7'b1000000 ("0").
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 captures num into the shift register, captures neg, clears the 28-bit BCD scratch and the bit counter, then goes to SHIFT. busy=1 from the next cycle.
- SHIFT, one bit per cycle:
  - Add 3 to each BCD nibble that is >=5.
  - Then shift {bcd, bin} left by 1.
  - After exactly WIDTH shifts, go to DONE.
- DONE, lasts one cycle:
  - Copy the 7 BCD digits and the sign into the display latch.
  - done=1, busy=0 in this cycle.
  - Return to IDLE.
- Latency: start sampled at cycle 0; done asserted at cycle WIDTH+1; the display shows the new value from cycle WIDTH+2.
- start while busy=1: ignored; the in-flight conversion is unaffected.
- start coincident with the DONE cycle: ignored; it must be re-issued.
- Reset mid-conversion: the conversion is aborted and the display latch returns to 0.
- The display keeps the previous value throughout a conversion; there is no flicker.
- Scan:
  - Counter runs 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At the terminal count the digit index increments mod 8 and anodos rotates left (FE -> FD -> ... -> 7F -> FE).
  - Sseg and anodos change in the same cycle.
- Digit mapping:
  - Index 0..6 = BCD digits, least to most significant.
  - Index 7 = sign slot: "-" (7'b0111111) when neg=1, blank (7'h7F) otherwise.
- -0 (num=0, neg=1) is shown as "-" plus "0".
- BCD values 10..15 are impossible by construction; the decoder maps them to blank.

Optional Feature:
- SSEG_LZB_EN (leading-zero blanking).
- Defined:
  - Digits above the most significant nonzero digit are blanked (7'h7F).
  - Digit 0 is never blanked.
  - The sign slot is unaffected.
  - Blanking is computed when the display latch is loaded.
- Undefined: all 7 digits are always shown, including leading zeros.

Decomposition:
- Shared package:
  - Segment constants: SEG_DIGIT[0:9], SEG_BLANK=7'h7F, SEG_MINUS=7'b0111111.
  - FSM state typedef {IDLE, SHIFT, DONE}.
  - BCD_DIGITS=7, NUM_DISPLAYS=8.
- Sub-module bcd_to_sseg: combinational 4-bit BCD plus blank flag -> 7-bit active-low pattern. Instantiated once, on the scan output.
- The double-dabble FSM and the scan counter stay in the top block.

Test Plan (SCAN_DIV=4 for simulation):
- Reset, then no start -> anodos=FE, Sseg=7'b1000000, busy=0. After 4 clocks anodos=FD; with SSEG_LZB_EN, Sseg=7F; without it, Sseg=7'b1000000.
- start, num=12345, neg=0 -> busy for cycles 1..20, done=1 at cycle 21. The scan shows digits 5,4,3,2,1 on indices 0..4 and blank on index 7.
- start, num=1048575, neg=1 -> digits 5,7,5,8,4,0,1 on indices 0..6; index 7 = 7'b0111111.
- Second start at cycle 5 of a conversion of 999 -> ignored. done pulses exactly once at cycle 21; display = 999.
- Assert rst at cycle 10 of a conversion -> busy=0 and anodos=FE immediately; done never pulses; display shows 0.
- Convert 42 then 7 back to back (second start the cycle after done) -> display shows 42 until the second done, then 7. Display latch bits never take an intermediate value.
